// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller.
// Tags and valid bits live in flops; the data array is an external RAM with one-cycle read latency.
module dcache_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int INDEX_W = 6,
  parameter int DATA_W  = 32
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                CpuReq,
  input  logic                CpuWe,
  input  logic [ADDR_W-1:0]   CpuAddr,
  input  logic [DATA_W-1:0]   CpuWData,
  output logic [DATA_W-1:0]   CpuRData,
  output logic                CpuReady,
  output logic [INDEX_W-1:0]  RamAddr,
  output logic [DATA_W-1:0]   RamDataIn,
  output logic                RamWrite,
  input  logic [DATA_W-1:0]   RamDataOut,
  output logic                MemReq,
  output logic                MemWe,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic [DATA_W-1:0]   MemWData,
  input  logic [DATA_W-1:0]   MemRData,
  input  logic                MemAck,
  output logic [15:0]         HitCnt,
  output logic [15:0]         MissCnt
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM_RD, MEM_WR} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic [15:0]         hit_cnt_q, hit_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q [LINES];
  logic                tag_we;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign idx = addr_q[INDEX_W-1:0];
  assign tag = addr_q[ADDR_W-1:INDEX_W];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  // Memory handshake: MemReq rises on entry to MEM_RD/MEM_WR and stays high with
  // MemAddr/MemWe/MemWData frozen (all sourced from the request latches) until the
  // cycle MemAck=1 is sampled; MemAck in any other state has no effect.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    tag_we     = 1'b0;
    RamAddr    = idx;
    RamDataIn  = wdata_q;
    RamWrite   = 1'b0;
    MemReq     = 1'b0;
    MemWe      = 1'b0;
    MemAddr    = addr_q;
    MemWData   = wdata_q;

    case (state_q)
      IDLE: begin
        RamAddr = CpuAddr[INDEX_W-1:0];
        if (CpuReq) begin
          we_d    = CpuWe;
          addr_d  = CpuAddr;
          wdata_d = CpuWData;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!we_q) begin
          if (hit) begin
            rdata_d   = RamDataOut;
            ready_d   = 1'b1;
            hit_cnt_d = sat_inc(hit_cnt_q);
            state_d   = IDLE;
          end else begin
            miss_cnt_d = sat_inc(miss_cnt_q);
            state_d    = MEM_RD;
          end
        end else begin
          // Write hit refreshes the cached copy; a write miss leaves the line alone.
          if (hit) begin
            RamWrite  = 1'b1;
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            miss_cnt_d = sat_inc(miss_cnt_q);
          end
          state_d = MEM_WR;
        end
      end
      MEM_RD: begin
        MemReq = 1'b1;
        if (MemAck) begin
          RamWrite     = 1'b1;
          RamDataIn    = MemRData;
          tag_we       = 1'b1;
          valid_d[idx] = 1'b1;
          rdata_d      = MemRData;
          ready_d      = 1'b1;
          state_d      = IDLE;
        end
      end
      MEM_WR: begin
        MemReq = 1'b1;
        MemWe  = 1'b1;
        if (MemAck) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
    end
  end

  // Tag contents are meaningless until the valid bit is set, so they carry no reset.
  always_ff @(posedge Clk) begin
    if (tag_we && !Rst) tag_q[idx] <= tag;
  end

  assign CpuRData = rdata_q;
  assign CpuReady = ready_q;
  assign HitCnt   = hit_cnt_q;
  assign MissCnt  = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed vector table, randomized traffic against a cache model,
// plus reset-abort and counter-saturation sequences.
module tb_dcache_ctrl;
  localparam int ADDR_W  = 16;
  localparam int INDEX_W = 6;
  localparam int DATA_W  = 32;
  localparam int LINES   = 1 << INDEX_W;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              CpuReq, CpuWe;
  logic [ADDR_W-1:0] CpuAddr;
  logic [DATA_W-1:0] CpuWData, CpuRData;
  logic              CpuReady;
  logic [INDEX_W-1:0] RamAddr;
  logic [DATA_W-1:0] RamDataIn, RamDataOut;
  logic              RamWrite;
  logic              MemReq, MemWe, MemAck;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData, MemRData;
  logic [15:0]       HitCnt, MissCnt;

  dcache_ctrl #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Rst(Rst), .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr),
    .CpuWData(CpuWData), .CpuRData(CpuRData), .CpuReady(CpuReady),
    .RamAddr(RamAddr), .RamDataIn(RamDataIn), .RamWrite(RamWrite), .RamDataOut(RamDataOut),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck), .HitCnt(HitCnt), .MissCnt(MissCnt)
  );

  // Clock / reset environment
  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Data-array RAM: registered read, read-before-write
  logic [DATA_W-1:0] ram [LINES];
  always @(posedge Clk) begin
    if (RamWrite) ram[RamAddr] <= RamDataIn;
    RamDataOut <= ram[RamAddr];
  end

  // Backing memory contents
  logic [DATA_W-1:0] bmem [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    if (!bmem.exists(a)) bmem[a] = {a ^ 16'h5A5A, ~a};
    return bmem[a];
  endfunction

  int checks = 0;
  int errors = 0;
  int cur_txn = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (txn %0d): got %0h expected %0h", name, cur_txn, act, exp);
    end
  endtask

  // Reference model: cache state at the level of lines and counters
  logic              m_valid [LINES];
  logic [9:0]        m_tag   [LINES];
  logic [DATA_W-1:0] m_data  [LINES];
  logic [15:0]       m_hit, m_miss;

  function automatic logic [15:0] sat_add(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_hit  = 16'd0;
    m_miss = 16'd0;
  endtask

  // Observations collected while a transaction runs
  int                obs_done, obs_lat, obs_ramw, obs_nreq, obs_unstable;
  logic [DATA_W-1:0] obs_rdata, obs_ramw_data, obs_memwd;
  logic [INDEX_W-1:0] obs_ramw_addr;
  logic [ADDR_W-1:0] obs_memaddr;
  logic              obs_memwe;

  // Driver: called at a negedge with the DUT in IDLE; returns at the negedge showing CpuReady.
  task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input int dly);
    int cyc;
    obs_done = 0; obs_lat = 0; obs_ramw = 0; obs_nreq = 0; obs_unstable = 0;
    obs_rdata = '0; obs_ramw_data = '0; obs_memwd = '0; obs_ramw_addr = '0;
    obs_memaddr = '0; obs_memwe = 1'b0;
    CpuReq = 1'b1; CpuWe = we; CpuAddr = addr; CpuWData = wd;
    @(negedge Clk);
    CpuReq = 1'b0; CpuWe = 1'($urandom_range(0, 1));
    CpuAddr = 16'($urandom); CpuWData = $urandom;
    cyc = 1;
    while (cyc < 40 && obs_done == 0) begin
      if (CpuReady) begin
        obs_done  = 1;
        obs_lat   = cyc;
        obs_rdata = CpuRData;
      end else begin
        if (MemReq) begin
          if (obs_nreq == 0) begin
            obs_memaddr = MemAddr; obs_memwe = MemWe; obs_memwd = MemWData;
          end else if (MemAddr !== obs_memaddr || MemWe !== obs_memwe || MemWData !== obs_memwd) begin
            obs_unstable = 1;
          end
          if (obs_nreq == dly) begin
            MemAck   = 1'b1;
            MemRData = mem_val(addr);
          end
          obs_nreq++;
        end
        #1;
        if (RamWrite) begin
          obs_ramw++;
          obs_ramw_data = RamDataIn;
          obs_ramw_addr = RamAddr;
        end
        @(negedge Clk);
        MemAck = 1'b0; MemRData = $urandom;
        cyc++;
      end
    end
  endtask

  // Scoreboard: predict the transaction from the model, compare, update the model.
  task automatic check_txn(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input int dly);
    int idx;
    logic hit;
    logic [DATA_W-1:0] exp_rd;
    idx = int'(addr[INDEX_W-1:0]);
    hit = m_valid[idx] && (m_tag[idx] == addr[ADDR_W-1:INDEX_W]);
    chk("ready_seen", 64'(obs_done), 64'd1);
    if (!we && hit) begin
      chk("hit_latency", 64'(obs_lat), 64'd2);
      chk("hit_rdata", 64'(obs_rdata), 64'(m_data[idx]));
      chk("hit_ramwrite", 64'(obs_ramw), 64'd0);
      chk("hit_memreq", 64'(obs_nreq), 64'd0);
      m_hit = sat_add(m_hit);
    end else begin
      chk("miss_latency", 64'(obs_lat), 64'(3 + dly));
      chk("memreq_cycles", 64'(obs_nreq), 64'(dly + 1));
      chk("memaddr", 64'(obs_memaddr), 64'(addr));
      chk("memwe", 64'(obs_memwe), 64'(we));
      chk("mem_stable", 64'(obs_unstable), 64'd0);
      if (!we) begin
        exp_rd = mem_val(addr);
        chk("fill_rdata", 64'(obs_rdata), 64'(exp_rd));
        chk("fill_ramwrite", 64'(obs_ramw), 64'd1);
        chk("fill_ramdata", 64'(obs_ramw_data), 64'(exp_rd));
        chk("fill_ramaddr", 64'(obs_ramw_addr), 64'(idx));
        m_valid[idx] = 1'b1;
        m_tag[idx]   = addr[ADDR_W-1:INDEX_W];
        m_data[idx]  = exp_rd;
        m_miss = sat_add(m_miss);
      end else begin
        chk("memwdata", 64'(obs_memwd), 64'(wd));
        chk("wr_ramwrite", 64'(obs_ramw), hit ? 64'd1 : 64'd0);
        if (hit) begin
          chk("wr_ramdata", 64'(obs_ramw_data), 64'(wd));
          m_data[idx] = wd;
          m_hit = sat_add(m_hit);
        end else begin
          m_miss = sat_add(m_miss);
        end
        bmem[addr] = wd;
      end
    end
    chk("hitcnt", 64'(HitCnt), 64'(m_hit));
    chk("misscnt", 64'(MissCnt), 64'(m_miss));
  endtask

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    int                dly;
    logic              exp_hit;
    logic [DATA_W-1:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int seen;
    logic we;
    logic [ADDR_W-1:0] a;

    vecs[0] = '{1'b0, 16'h0041, 32'h0,        2, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 16'h0041, 32'h0,        0, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 16'h0041, 32'h12345678, 1, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 16'h0041, 32'h0,        0, 1'b1, 32'h12345678};
    vecs[4] = '{1'b1, 16'h0081, 32'hCAFEF00D, 0, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 16'h0041, 32'h0,        0, 1'b1, 32'h12345678};
    vecs[6] = '{1'b0, 16'h0081, 32'h0,        0, 1'b0, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 16'h0041, 32'h0,        3, 1'b0, 32'h12345678};
    bmem[16'h0041] = 32'hDEADBEEF;

    Rst = 1'b1; CpuReq = 1'b0; CpuWe = 1'b0; CpuAddr = '0; CpuWData = '0;
    MemAck = 1'b0; MemRData = '0;
    for (int i = 0; i < LINES; i++) ram[i] = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ready", 64'(CpuReady), 64'd0);
    chk("rst_rdata", 64'(CpuRData), 64'd0);
    chk("rst_memreq", 64'(MemReq), 64'd0);
    chk("rst_memwe", 64'(MemWe), 64'd0);
    chk("rst_ramwrite", 64'(RamWrite), 64'd0);
    chk("rst_hitcnt", 64'(HitCnt), 64'd0);
    chk("rst_misscnt", 64'(MissCnt), 64'd0);
    Rst = 1'b0;
    @(negedge Clk);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      cur_txn = i;
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].dly);
      if (!vecs[i].we) begin
        chk("vec_hit", (obs_lat == 2) ? 64'd1 : 64'd0, 64'(vecs[i].exp_hit));
        chk("vec_rdata", 64'(obs_rdata), 64'(vecs[i].exp_rd));
      end else begin
        chk("vec_wr_hit", 64'(obs_ramw), 64'(vecs[i].exp_hit));
      end
      check_txn(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].dly);
    end
    chk("vec_hitcnt", 64'(HitCnt), 64'd4);
    chk("vec_misscnt", 64'(MissCnt), 64'd4);

    // Randomized traffic over a small tag/index space to mix hits and conflicts
    for (int i = 0; i < 150; i++) begin
      cur_txn = 100 + i;
      we = ($urandom_range(0, 2) == 0);
      a  = 16'(($urandom_range(0, 3) << INDEX_W) | $urandom_range(0, 3));
      begin
        logic [DATA_W-1:0] wd;
        int dly;
        wd  = $urandom;
        dly = $urandom_range(0, 3);
        run_txn(we, a, wd, dly);
        check_txn(we, a, wd, dly);
      end
    end

    // Reset while a read miss waits on memory
    cur_txn = 500;
    CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 16'h30C5;
    @(negedge Clk);
    CpuReq = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      if (MemReq) seen = 1;
      else @(negedge Clk);
    end
    chk("abort_memreq_seen", 64'(seen), 64'd1);
    Rst = 1'b1; MemAck = 1'b1; MemRData = 32'h0BADF00D;
    @(negedge Clk);
    Rst = 1'b0; MemAck = 1'b0;
    chk("abort_memreq", 64'(MemReq), 64'd0);
    chk("abort_ready", 64'(CpuReady), 64'd0);
    chk("abort_rdata", 64'(CpuRData), 64'd0);
    chk("abort_hitcnt", 64'(HitCnt), 64'd0);
    chk("abort_misscnt", 64'(MissCnt), 64'd0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      MemAck = (c == 1);
      @(negedge Clk);
      if (CpuReady || MemReq) seen = 1;
    end
    MemAck = 1'b0;
    chk("abort_quiet", 64'(seen), 64'd0);
    model_reset();
    cur_txn = 501;
    run_txn(1'b0, 16'h0041, 32'h0, 0);
    check_txn(1'b0, 16'h0041, 32'h0, 0);
    cur_txn = 502;
    run_txn(1'b0, 16'h30C5, 32'h0, 1);
    check_txn(1'b0, 16'h30C5, 32'h0, 1);

    // Counter saturation
    cur_txn = 600;
    force dut.hit_cnt_q = 16'hFFFD;
    @(negedge Clk);
    release dut.hit_cnt_q;
    m_hit = 16'hFFFD;
    for (int i = 0; i < 3; i++) begin
      cur_txn = 601 + i;
      run_txn(1'b0, 16'h0041, 32'h0, 0);
      check_txn(1'b0, 16'h0041, 32'h0, 0);
    end
    chk("hit_saturated", 64'(HitCnt), 64'hFFFF);
    cur_txn = 610;
    force dut.miss_cnt_q = 16'hFFFF;
    @(negedge Clk);
    release dut.miss_cnt_q;
    m_miss = 16'hFFFF;
    run_txn(1'b0, 16'h0081, 32'h0, 0);
    check_txn(1'b0, 16'h0081, 32'h0, 0);
    chk("miss_saturated", 64'(MissCnt), 64'hFFFF);

    repeat (2) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, default 16, word address width; INDEX_W, default 6, cache index width (2^INDEX_W lines, one word per line); DATA_W, default 32, data width; TAG_W = ADDR_W-INDEX_W, derived.
REQ-002 SHALL have a single clock `Clk` and reset `Rst`; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- Clk  in  1  clock, all logic on posedge
- Rst  in  1  synchronous active-high reset
- CpuReq  in  1  CPU request strobe, sampled only in IDLE
- CpuWe  in  1  1 = write, 0 = read
- CpuAddr  in  ADDR_W  word address; index = low INDEX_W bits, tag = upper TAG_W bits
- CpuWData  in  DATA_W  write data
- CpuRData  out  DATA_W  read data, valid when CpuReady=1 on a read
- CpuReady  out  1  one-cycle completion pulse
- RamAddr  out  INDEX_W  data-array address
- RamDataIn  out  DATA_W  data-array write data
- RamWrite  out  1  data-array write enable
- RamDataOut  in  DATA_W  data-array read data, one-cycle registered latency
- MemReq  out  1  memory request, held until MemAck
- MemWe  out  1  memory write qualifier
- MemAddr  out  ADDR_W  memory word address
- MemWData  out  DATA_W  memory write data
- MemRData  in  DATA_W  memory read data, valid with MemAck
- MemAck  in  1  one-cycle memory completion
- HitCnt  out  16  saturating hit counter
- MissCnt  out  16  saturating miss counter

Function
REQ-004 SHALL be a direct-mapped, write-through, no-write-allocate controller; it keeps the tag array (TAG_W per line) and valid bits internally in flops.
REQ-005 FSM states SHALL be IDLE, LOOKUP, MEM_RD, MEM_WR.
REQ-006 IDLE with CpuReq=1: latch CpuWe, CpuAddr and CpuWData; drive RamAddr=index; go to LOOKUP. With CpuReq=0: stay in IDLE.
REQ-007 RamAddr SHALL hold the latched index in all states other than IDLE.
REQ-008 LOOKUP: hit = valid[index] && tag[index]==latched tag, evaluated against the current tag/valid contents.
REQ-009 LOOKUP read hit: CpuRData=RamDataOut, CpuReady=1, HitCnt+1, next state IDLE (latency 2 cycles from accept to CpuReady).
REQ-010 LOOKUP read miss: MissCnt+1, go to MEM_RD.
REQ-011 LOOKUP write hit: RamWrite=1 and RamDataIn=latched wdata in this cycle; HitCnt+1; go to MEM_WR. LOOKUP write miss: no RAM write, tag and valid unchanged, MissCnt+1, go to MEM_WR.
REQ-012 MEM_RD: MemReq=1, MemWe=0, MemAddr=latched addr. When MemAck=1: RamWrite=1, RamDataIn=MemRData, tag[index]=latched tag, valid[index]=1, CpuRData=MemRData, CpuReady=1, next state IDLE.
REQ-013 MEM_WR: MemReq=1, MemWe=1, MemAddr=latched addr, MemWData=latched wdata. When MemAck=1: CpuReady=1, next state IDLE.
REQ-014 MemReq SHALL remain asserted, with stable MemAddr, MemWe and MemWData, every cycle until MemAck is received; MemAck outside MEM_RD or MEM_WR SHALL be ignored.
REQ-015 MemAck arriving in the first cycle of MEM_RD or MEM_WR SHALL complete the state (minimum miss latency 3 cycles).
REQ-016 CpuReady SHALL be exactly one cycle wide. CpuRData SHALL hold its last value when CpuReady=0. CpuReq during non-IDLE states SHALL be ignored.
REQ-017 RamWrite SHALL be 0 except in the cases of REQ-011 and REQ-012. MemReq and MemWe SHALL be 0 in IDLE and LOOKUP.
REQ-018 HitCnt and MissCnt SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-019 With Rst=1 at a posedge: state=IDLE, all valid bits=0, HitCnt=0, MissCnt=0, CpuReady=0, CpuRData=0, MemReq=0, MemWe=0, RamWrite=0.
REQ-020 Reset during MEM_RD or MEM_WR SHALL abort the transaction (MemReq=0 the next cycle) with no tag update and no CpuReady pulse.

Verification
REQ-021 Reset, then read 0x0041 (index 1, tag 1) with MemAck 2 cycles later returning 0xDEADBEEF -> MemReq held until ack, RamWrite of 0xDEADBEEF at index 1, CpuReady with CpuRData=0xDEADBEEF, MissCnt=1.
REQ-022 Read 0x0041 again -> CpuReady 2 cycles after accept, CpuRData=0xDEADBEEF, no MemReq, HitCnt=1.
REQ-023 Write 0x12345678 to 0x0041 -> RamWrite in LOOKUP, MemReq/MemWe with MemWData=0x12345678; subsequent read hits and returns 0x12345678.
REQ-024 Write to 0x0081 (same index, different tag) -> no RamWrite, memory write only; read 0x0041 still hits.
REQ-025 Read miss with Rst asserted while MemReq=1 -> MemReq=0 the next cycle, no CpuReady, all valid bits cleared, counters=0.
REQ-026 Preload HitCnt to 0xFFFF via repeated hits (or force), then one more hit -> HitCnt stays 0xFFFF.
